// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : inst_mem_loader
// Purpose  : Instruction memory answering CPU fetches combinationally, with a
//            byte-serial program-load port that refills it at run time.
//            Fetches return NOP (0x00000000) while a load is in progress.
// Revision : 1.0  initial release
// ============================================================================
module inst_mem_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic [31:0] addr_i,
  output logic [31:0] inst_o,
  input  logic        load_start_i,
  input  logic        load_valid_i,
  input  logic [7:0]  load_byte_i,
  output logic        load_ready_o,
  output logic        load_busy_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  localparam int          c_depth_words = 2 ** ADDR_WIDTH;
  localparam logic [16:0] c_depth       = 17'(c_depth_words);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEN_HI = 2'd1,
    ST_LEN_LO = 2'd2,
    ST_DATA   = 2'd3
  } state_t;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;
  logic [ADDR_WIDTH:0]   r_ptr;     // one extra bit so it can reach N == depth
  logic [1:0]            r_cnt;     // byte position within the current word
  logic [15:0]           r_len;     // word count N from the stream header
  logic [23:0]           r_asm;     // first three bytes of the word in flight
  logic [31:0]           r_mem [c_depth_words];

  logic                  w_accept;
  logic [15:0]           w_len_full;
  logic [31:0]           w_word;
  logic                  w_word_wr;
  logic [ADDR_WIDTH:0]   w_ptr_next;
  logic                  w_last_word;
  logic                  w_fetch_ok;
  logic                  w_unused_addr;

  // Byte lanes are irrelevant to a word-wide instruction fetch.
  assign w_unused_addr = ^addr_i[1:0];

  assign load_ready_o = (r_state != ST_IDLE) && !load_start_i;
  assign load_busy_o  = r_busy;
  assign load_done_o  = r_done;
  assign load_err_o   = r_err;

  assign w_accept    = load_valid_i && load_ready_o;
  assign w_len_full  = {r_len[15:8], load_byte_i};
  assign w_word      = {r_asm, load_byte_i};
  assign w_word_wr   = w_accept && (r_state == ST_DATA) && (r_cnt == 2'd3);
  assign w_ptr_next  = r_ptr + 1'b1;
  assign w_last_word = (17'(w_ptr_next) == {1'b0, r_len});

  assign w_fetch_ok  = ce_i && !r_busy && (addr_i[31:ADDR_WIDTH+2] == '0);

  // Zero-latency ROM-style fetch; out-of-range, disabled or mid-load reads give NOP.
  always_comb begin
    inst_o = 32'h0000_0000;
    if (w_fetch_ok) begin
      inst_o = r_mem[addr_i[ADDR_WIDTH+1:2]];
    end
  end

  // Memory array is deliberately not reset so a loaded program survives rst.
  always_ff @(posedge clk) begin
    if (w_word_wr) begin
      r_mem[r_ptr[ADDR_WIDTH-1:0]] <= w_word;
    end
  end

  // Load-stream parser: header count, then big-endian words; start restarts from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= 2'd0;
      r_len   <= 16'h0000;
      r_asm   <= 24'h00_0000;
    end else begin
      r_done <= 1'b0;
      if (load_start_i) begin
        r_state <= ST_LEN_HI;
        r_busy  <= 1'b1;
        r_err   <= 1'b0;
        r_ptr   <= '0;
        r_cnt   <= 2'd0;
      end else if (w_accept) begin
        case (r_state)
          ST_LEN_HI: begin
            r_len[15:8] <= load_byte_i;
            r_state     <= ST_LEN_LO;
          end
          ST_LEN_LO: begin
            r_len[7:0] <= load_byte_i;
            if (w_len_full == 16'h0000) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else if ({1'b0, w_len_full} > c_depth) begin
              // Oversize program: reject before touching memory.
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_err   <= 1'b1;
            end else begin
              r_state <= ST_DATA;
            end
          end
          ST_DATA: begin
            r_asm <= {r_asm[15:0], load_byte_i};
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_ptr <= w_ptr_next;
              if (w_last_word) begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_mem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_mem_loader
// Purpose  : Directed bench for inst_mem_loader with a byte-stream model and
//            per-cycle output comparison.
// Revision : 1.0  initial release
// ============================================================================
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce_i;
  logic [31:0] addr_i;
  logic [31:0] inst_o;
  logic        load_start_i;
  logic        load_valid_i;
  logic [7:0]  load_byte_i;
  logic        load_ready_o;
  logic        load_busy_o;
  logic        load_done_o;
  logic        load_err_o;

  int n_vec = 0;
  int n_bad = 0;
  int done_pulses = 0;
  int done_mark;

  // Model: the load stream as a byte index k (0,1 = count, 2.. = data).
  logic [31:0] m_mem   [1024];
  bit          m_known [1024];
  bit          m_busy = 1'b0;
  bit          m_err  = 1'b0;
  bit          m_done = 1'b0;
  int          m_k    = 0;
  int          m_len  = 0;
  logic [31:0] m_acc  = 32'h0;

  inst_mem_loader #(.ADDR_WIDTH(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .ce_i         (ce_i),
    .addr_i       (addr_i),
    .inst_o       (inst_o),
    .load_start_i (load_start_i),
    .load_valid_i (load_valid_i),
    .load_byte_i  (load_byte_i),
    .load_ready_o (load_ready_o),
    .load_busy_o  (load_busy_o),
    .load_done_o  (load_done_o),
    .load_err_o   (load_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update: interprets the accepted byte stream.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0;
      m_err  = 1'b0;
      m_done = 1'b0;
      m_k    = 0;
    end else begin
      m_done = 1'b0;
      if (load_start_i) begin
        m_busy = 1'b1;
        m_err  = 1'b0;
        m_k    = 0;
        m_len  = 0;
      end else if (m_busy && load_valid_i) begin
        if (m_k == 0) begin
          m_len = 256 * int'(load_byte_i);
          m_k   = 1;
        end else if (m_k == 1) begin
          m_len = m_len + int'(load_byte_i);
          if (m_len == 0) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end else if (m_len > 1024) begin
            m_busy = 1'b0;
            m_err  = 1'b1;
          end else begin
            m_k = 2;
          end
        end else begin
          m_acc = {m_acc[23:0], load_byte_i};
          m_k   = m_k + 1;
          if ((m_k - 2) % 4 == 0) begin
            int idx;
            idx = (m_k - 2) / 4 - 1;
            m_mem[idx]   = m_acc;
            m_known[idx] = 1'b1;
            if (idx + 1 == m_len) begin
              m_busy = 1'b0;
              m_done = 1'b1;
            end
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (load_done_o === 1'b1) done_pulses++;
    chk("busy",  {31'b0, load_busy_o},  {31'b0, m_busy});
    chk("done",  {31'b0, load_done_o},  {31'b0, m_done});
    chk("err",   {31'b0, load_err_o},   {31'b0, m_err});
    chk("ready", {31'b0, load_ready_o}, {31'b0, (m_busy && !load_start_i)});
    if (ce_i && !m_busy && (addr_i[31:12] == 20'h0)) begin
      if (m_known[addr_i[11:2]]) chk("inst", inst_o, m_mem[addr_i[11:2]]);
    end else begin
      chk("inst_nop", inst_o, 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    load_valid_i = 1'b1;
    load_byte_i  = b;
    tick();
    load_valid_i = 1'b0;
  endtask

  task automatic start_pulse();
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] a, input logic [31:0] exp, input string name);
    ce_i   = 1'b1;
    addr_i = a;
    @(negedge clk);
    chk(name, inst_o, exp);
    tick();
    ce_i = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    ce_i         = 1'b0;
    addr_i       = 32'h0;
    load_start_i = 1'b0;
    load_valid_i = 1'b0;
    load_byte_i  = 8'h00;
    repeat (2) tick();
    chk("rst_busy",  {31'b0, load_busy_o},  32'd0);
    chk("rst_ready", {31'b0, load_ready_o}, 32'd0);
    chk("rst_done",  {31'b0, load_done_o},  32'd0);
    chk("rst_err",   {31'b0, load_err_o},   32'd0);
    chk("rst_inst",  inst_o,                32'd0);
    rst = 1'b0;
    tick();

    // 1: two-word load, fetch held at addr 0 throughout.
    done_mark = done_pulses;
    ce_i   = 1'b1;
    addr_i = 32'h0;
    start_pulse();
    send_byte(8'h00);
    tick();
    send_byte(8'h02);
    foreach (m_acc[i]) begin end
    send_byte(8'h34); send_byte(8'h01);
    @(negedge clk);
    chk("t1_busy_mid", {31'b0, load_busy_o}, 32'd1);
    chk("t1_nop_mid",  inst_o,               32'd0);
    tick();
    send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h0C);
    @(negedge clk);
    chk("t1_done", {31'b0, load_done_o}, 32'd1);
    tick();
    tick();
    ce_i = 1'b0;
    chk("t1_done_once", done_pulses - done_mark, 32'd1);
    fetch(32'h0, 32'h3401_0005, "t1_word0");
    fetch(32'h4, 32'h0000_000C, "t1_word1");

    // 2: oversize count 1025 rejected.
    done_mark = done_pulses;
    start_pulse();
    send_byte(8'h04);
    send_byte(8'h01);
    @(negedge clk);
    chk("t2_err",  {31'b0, load_err_o},  32'd1);
    chk("t2_busy", {31'b0, load_busy_o}, 32'd0);
    tick();
    chk("t2_no_done", done_pulses - done_mark, 32'd0);
    fetch(32'h0, 32'h3401_0005, "t2_word0_kept");
    start_pulse();
    @(negedge clk);
    chk("t2_err_clr", {31'b0, load_err_o}, 32'd0);
    tick();

    // 3: zero-length load.
    done_mark = done_pulses;
    start_pulse();
    send_byte(8'h00);
    send_byte(8'h00);
    @(negedge clk);
    chk("t3_done", {31'b0, load_done_o}, 32'd1);
    tick();
    @(negedge clk);
    chk("t3_done_low", {31'b0, load_done_o}, 32'd0);
    tick();
    chk("t3_done_once", done_pulses - done_mark, 32'd1);
    fetch(32'h0, 32'h3401_0005, "t3_word0_kept");

    // 4: aborted load, restart with coincident (dropped) byte.
    start_pulse();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
    send_byte(8'h11);
    load_start_i = 1'b1;
    load_valid_i = 1'b1;
    load_byte_i  = 8'h99;
    @(negedge clk);
    chk("t4_ready_drop", {31'b0, load_ready_o}, 32'd0);
    tick();
    load_start_i = 1'b0;
    load_valid_i = 1'b0;
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12); send_byte(8'h34); send_byte(8'h56); send_byte(8'h78);
    tick();
    fetch(32'h0, 32'h1234_5678, "t4_word0");
    fetch(32'h4, 32'h0000_000C, "t4_word1_kept");

    // 5: reset after six data bytes of a two-word load.
    start_pulse();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
    send_byte(8'h55); send_byte(8'h66);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy",  {31'b0, load_busy_o},  32'd0);
    chk("t5_rst_ready", {31'b0, load_ready_o}, 32'd0);
    chk("t5_rst_done",  {31'b0, load_done_o},  32'd0);
    load_valid_i = 1'b1;
    load_byte_i  = 8'h77;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_idle_ready", {31'b0, load_ready_o}, 32'd0);
    tick();
    load_valid_i = 1'b0;
    tick();
    fetch(32'h0, 32'hDEAD_BEEF, "t5_word0");
    fetch(32'h4, 32'h0000_000C, "t5_word1_kept");

    // 6: fetch gating and address decode.
    ce_i   = 1'b0;
    addr_i = 32'h4;
    @(negedge clk);
    chk("t6_ce_off", inst_o, 32'h0);
    tick();
    fetch(32'h0000_1000, 32'h0, "t6_out_of_range");
    fetch(32'h7, 32'h0000_000C, "t6_byte_lanes");

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
